// File: rtl/vrf_ctrl_pkg.sv
// Shared types and width helpers for the vector register file access controller.
package vrf_ctrl_pkg;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ISSUE  = 2'd1,
    R_FETCH  = 2'd2,
    R_STREAM = 2'd3
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_DATA = 2'd2
  } wr_state_e;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_bits(input int reg_num);
    return idx_bits(reg_num);
  endfunction

  function automatic int elem_bits(input int lanes);
    return idx_bits(lanes);
  endfunction

endpackage

// File: rtl/vrf_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last winner.
// Until the first grant after reset the search starts at requester 0.
module rr_arbiter
  import vrf_ctrl_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int REQ_B = idx_bits(NREQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ-1:0]  elig_i,
  input  logic             upd_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [REQ_B-1:0] gnt_idx_o,
  output logic             gnt_any_o
);

  logic [REQ_B-1:0] ptr_q, ptr_d;
  logic             ptr_vld_q, ptr_vld_d;

  always_comb begin
    int               base;
    int               cand;
    logic             found;
    logic [REQ_B-1:0] sel;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sel       = '0;
    base      = ptr_vld_q ? int'(ptr_q) : NREQ - 1;
    for (int off = 1; off <= NREQ; off++) begin
      cand = base + off;
      if (cand >= NREQ) cand = cand - NREQ;
      sel = REQ_B'(cand);
      if (!found && req_i[sel] && elig_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        gnt_idx_o  = sel;
      end
    end
    gnt_any_o = found;
  end

  always_comb begin
    ptr_d     = upd_i ? gnt_idx_o : ptr_q;
    ptr_vld_d = ptr_vld_q | upd_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      ptr_vld_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      ptr_vld_q <= ptr_vld_d;
    end
  end

endmodule

// File: rtl/vrf_access_ctrl.sv
// Shares the banked VRF between NREQ read requesters and one write-back stream.
// Handshakes: a transfer happens in a cycle where valid and ready are both high;
// valid is never withdrawn by the producer before that cycle.
module vrf_access_ctrl
  import vrf_ctrl_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int REG_NUM    = 32,
  parameter  int LANES      = 4,
  parameter  int NREQ       = 2,
  localparam int ADDR_B     = addr_bits(REG_NUM),
  localparam int ELEM_B     = elem_bits(LANES),
  localparam int REQ_B      = idx_bits(NREQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        rq_valid_i,
  input  logic [NREQ*ADDR_B-1:0] rq_a_addr_i,
  input  logic [NREQ*ADDR_B-1:0] rq_b_addr_i,
  input  logic [NREQ*ADDR_B-1:0] rq_c_addr_i,
  input  logic [NREQ-1:0]        rq_use_c_i,
  output logic [NREQ-1:0]        rq_grant_o,
  output logic                   op_valid_o,
  output logic [ELEM_B-1:0]      op_idx_o,
  output logic [REQ_B-1:0]       op_owner_o,
  output logic                   op_last_o,
  input  logic                   op_ready_i,
  input  logic                   wcmd_valid_i,
  input  logic [ADDR_B-1:0]      wcmd_addr_i,
  output logic                   wcmd_ready_o,
  input  logic                   wdat_valid_i,
  input  logic [DATA_WIDTH-1:0]  wdat_i,
  output logic                   wdat_ready_o,
  output logic [ADDR_B-1:0]      vrf_a_addr_o,
  output logic [ADDR_B-1:0]      vrf_b_addr_o,
  output logic [ADDR_B-1:0]      vrf_c_addr_o,
  output logic                   vrf_rd_req_o,
  output logic                   vrf_is_c_used_o,
  input  logic                   vrf_rd_op_ready_i,
  output logic [ELEM_B-1:0]      vrf_rd_elem_cnt_o,
  output logic [ADDR_B-1:0]      vrf_wr_addr_o,
  output logic                   vrf_wr_req_o,
  output logic                   vrf_wr_en_o,
  output logic                   vrf_wr_ready_o,
  output logic [ELEM_B-1:0]      vrf_wr_elem_cnt_o,
  output logic [DATA_WIDTH-1:0]  vrf_wdata_o,
  output rd_state_e              dbg_rd_state_o,
  output wr_state_e              dbg_wr_state_o
);

  localparam logic [ELEM_B-1:0] ELEM_LAST = ELEM_B'(LANES - 1);

  rd_state_e         rd_state_q, rd_state_d;
  logic [ELEM_B-1:0] cnt_q, cnt_d;
  logic [REQ_B-1:0]  owner_q, owner_d;
  logic [ADDR_B-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic              use_c_q, use_c_d;

  wr_state_e         wr_state_q, wr_state_d;
  logic [ELEM_B-1:0] wcnt_q, wcnt_d;
  logic [ADDR_B-1:0] waddr_q, waddr_d;

  logic [ADDR_B-1:0] a_addr [NREQ];
  logic [ADDR_B-1:0] b_addr [NREQ];
  logic [ADDR_B-1:0] c_addr [NREQ];
  logic [NREQ-1:0]   haz;
  logic              wr_busy;

  logic [NREQ-1:0]   arb_gnt;
  logic [REQ_B-1:0]  arb_idx;
  logic              arb_any;
  logic              arb_upd;

  logic [NREQ-1:0]   grant;
  logic              rd_req;
  logic              op_valid;
  logic              wcmd_ready;
  logic              wr_req;
  logic              wdat_ready;
  logic              wr_en;
  logic              wr_ready;

  // A requester reading the register currently being written must wait until
  // the whole destination register has been written back.
  assign wr_busy = (wr_state_q == W_REQ) || (wr_state_q == W_DATA);

  always_comb begin
    haz = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_addr[i] = rq_a_addr_i[i*ADDR_B +: ADDR_B];
      b_addr[i] = rq_b_addr_i[i*ADDR_B +: ADDR_B];
      c_addr[i] = rq_c_addr_i[i*ADDR_B +: ADDR_B];
      haz[i]    = wr_busy && ((waddr_q == a_addr[i]) || (waddr_q == b_addr[i]) ||
                              (rq_use_c_i[i] && (waddr_q == c_addr[i])));
    end
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (rq_valid_i),
    .elig_i    (~haz),
    .upd_i     (arb_upd),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .gnt_any_o (arb_any)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    rc_d       = rc_q;
    use_c_d    = use_c_q;
    grant      = '0;
    rd_req     = 1'b0;
    op_valid   = 1'b0;
    arb_upd    = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (arb_any && !rst_i) begin
          grant      = arb_gnt;
          arb_upd    = 1'b1;
          owner_d    = arb_idx;
          ra_d       = a_addr[arb_idx];
          rb_d       = b_addr[arb_idx];
          rc_d       = c_addr[arb_idx];
          use_c_d    = rq_use_c_i[arb_idx];
          rd_state_d = R_ISSUE;
        end
      end
      R_ISSUE: begin
        rd_req     = 1'b1;
        rd_state_d = R_FETCH;
      end
      R_FETCH: begin
        if (vrf_rd_op_ready_i) rd_state_d = R_STREAM;
      end
      R_STREAM: begin
        op_valid = 1'b1;
        if (op_ready_i) begin
          if (cnt_q == ELEM_LAST) begin
            cnt_d      = '0;
            rd_state_d = R_IDLE;
          end else begin
            cnt_d = cnt_q + ELEM_B'(1);
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wcnt_d     = wcnt_q;
    waddr_d    = waddr_q;
    wcmd_ready = 1'b0;
    wr_req     = 1'b0;
    wdat_ready = 1'b0;
    wr_en      = 1'b0;
    wr_ready   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        wcmd_ready = !rst_i;
        if (wcmd_valid_i) begin
          waddr_d    = wcmd_addr_i;
          wr_state_d = W_REQ;
        end
      end
      W_REQ: begin
        wr_req     = 1'b1;
        wr_state_d = W_DATA;
      end
      W_DATA: begin
        wdat_ready = 1'b1;
        if (wdat_valid_i) begin
          wr_en = 1'b1;
          if (wcnt_q == ELEM_LAST) begin
            wr_ready   = 1'b1;
            wcnt_d     = '0;
            wr_state_d = W_IDLE;
          end else begin
            wcnt_d = wcnt_q + ELEM_B'(1);
          end
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      cnt_q      <= '0;
      owner_q    <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      rc_q       <= '0;
      use_c_q    <= 1'b0;
      wr_state_q <= W_IDLE;
      wcnt_q     <= '0;
      waddr_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      rc_q       <= rc_d;
      use_c_q    <= use_c_d;
      wr_state_q <= wr_state_d;
      wcnt_q     <= wcnt_d;
      waddr_q    <= waddr_d;
    end
  end

  assign rq_grant_o        = grant;
  assign op_valid_o        = op_valid;
  assign op_idx_o          = cnt_q;
  assign op_owner_o        = owner_q;
  assign op_last_o         = op_valid && (cnt_q == ELEM_LAST);
  assign vrf_a_addr_o      = ra_q;
  assign vrf_b_addr_o      = rb_q;
  assign vrf_c_addr_o      = rc_q;
  assign vrf_rd_req_o      = rd_req;
  assign vrf_is_c_used_o   = use_c_q;
  assign vrf_rd_elem_cnt_o = cnt_q;
  assign wcmd_ready_o      = wcmd_ready;
  assign wdat_ready_o      = wdat_ready;
  assign vrf_wr_addr_o     = waddr_q;
  assign vrf_wr_req_o      = wr_req;
  assign vrf_wr_en_o       = wr_en;
  assign vrf_wr_ready_o    = wr_ready;
  assign vrf_wr_elem_cnt_o = wcnt_q;
  assign vrf_wdata_o       = wdat_i;
  assign dbg_rd_state_o    = rd_state_q;
  assign dbg_wr_state_o    = wr_state_q;

endmodule

// File: tb/tb_vrf_access_ctrl.sv
// Directed bench for vrf_access_ctrl with a small VRF read-completion model
// and per-event expected queues checked by a negedge monitor.
module tb_vrf_access_ctrl;
  import vrf_ctrl_pkg::*;

  localparam int DW = 32;
  localparam int AB = 5;
  localparam int EB = 2;
  localparam int NR = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   rq_valid_i;
  logic [NR*AB-1:0] rq_a_addr_i, rq_b_addr_i, rq_c_addr_i;
  logic [NR-1:0]   rq_use_c_i;
  logic [NR-1:0]   rq_grant_o;
  logic            op_valid_o;
  logic [EB-1:0]   op_idx_o;
  logic            op_owner_o;
  logic            op_last_o;
  logic            op_ready_i;
  logic            wcmd_valid_i;
  logic [AB-1:0]   wcmd_addr_i;
  logic            wcmd_ready_o;
  logic            wdat_valid_i;
  logic [DW-1:0]   wdat_i;
  logic            wdat_ready_o;
  logic [AB-1:0]   vrf_a_addr_o, vrf_b_addr_o, vrf_c_addr_o;
  logic            vrf_rd_req_o;
  logic            vrf_is_c_used_o;
  logic            vrf_rd_op_ready_i;
  logic [EB-1:0]   vrf_rd_elem_cnt_o;
  logic [AB-1:0]   vrf_wr_addr_o;
  logic            vrf_wr_req_o, vrf_wr_en_o, vrf_wr_ready_o;
  logic [EB-1:0]   vrf_wr_elem_cnt_o;
  logic [DW-1:0]   vrf_wdata_o;
  rd_state_e       dbg_rd_state_o;
  wr_state_e       dbg_wr_state_o;

  vrf_access_ctrl #(
    .DATA_WIDTH (DW), .REG_NUM (32), .LANES (4), .NREQ (NR)
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .rq_valid_i (rq_valid_i), .rq_a_addr_i (rq_a_addr_i), .rq_b_addr_i (rq_b_addr_i),
    .rq_c_addr_i (rq_c_addr_i), .rq_use_c_i (rq_use_c_i), .rq_grant_o (rq_grant_o),
    .op_valid_o (op_valid_o), .op_idx_o (op_idx_o), .op_owner_o (op_owner_o),
    .op_last_o (op_last_o), .op_ready_i (op_ready_i),
    .wcmd_valid_i (wcmd_valid_i), .wcmd_addr_i (wcmd_addr_i), .wcmd_ready_o (wcmd_ready_o),
    .wdat_valid_i (wdat_valid_i), .wdat_i (wdat_i), .wdat_ready_o (wdat_ready_o),
    .vrf_a_addr_o (vrf_a_addr_o), .vrf_b_addr_o (vrf_b_addr_o), .vrf_c_addr_o (vrf_c_addr_o),
    .vrf_rd_req_o (vrf_rd_req_o), .vrf_is_c_used_o (vrf_is_c_used_o),
    .vrf_rd_op_ready_i (vrf_rd_op_ready_i), .vrf_rd_elem_cnt_o (vrf_rd_elem_cnt_o),
    .vrf_wr_addr_o (vrf_wr_addr_o), .vrf_wr_req_o (vrf_wr_req_o), .vrf_wr_en_o (vrf_wr_en_o),
    .vrf_wr_ready_o (vrf_wr_ready_o), .vrf_wr_elem_cnt_o (vrf_wr_elem_cnt_o),
    .vrf_wdata_o (vrf_wdata_o), .dbg_rd_state_o (dbg_rd_state_o), .dbg_wr_state_o (dbg_wr_state_o)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard queues ----------------
  logic [17:0] gnt_q[$];  // {cycle, grant}
  logic [31:0] rdr_q[$];  // {cycle, a, b, c, use_c}
  logic [35:0] op_q[$];   // {cycle, owner, idx, last, a, b, c, use_c}
  logic [20:0] wrq_q[$];  // {cycle, wr_addr}
  logic [55:0] wr_q[$];   // {cycle, wr_addr, elem_cnt, wdata, wr_ready}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (rq_grant_o != '0) begin
      if (gnt_q.size() == 0) unexpected("grant", {16'(cyc), rq_grant_o});
      else check("grant", {16'(cyc), rq_grant_o}, gnt_q.pop_front());
    end
    if (vrf_rd_req_o) begin
      if (rdr_q.size() == 0) unexpected("rd_req", {16'(cyc), vrf_a_addr_o});
      else check("rd_req", {16'(cyc), vrf_a_addr_o, vrf_b_addr_o, vrf_c_addr_o, vrf_is_c_used_o},
                 rdr_q.pop_front());
    end
    if (op_valid_o && op_ready_i) begin
      if (op_q.size() == 0) unexpected("operand", {16'(cyc), op_owner_o, op_idx_o});
      else check("operand", {16'(cyc), op_owner_o, op_idx_o, op_last_o, vrf_a_addr_o,
                             vrf_b_addr_o, vrf_c_addr_o, vrf_is_c_used_o}, op_q.pop_front());
    end
    if (op_valid_o && (vrf_rd_elem_cnt_o !== op_idx_o))
      check("rd_elem_cnt", vrf_rd_elem_cnt_o, op_idx_o);
    if (vrf_wr_req_o) begin
      if (wrq_q.size() == 0) unexpected("wr_req", {16'(cyc), vrf_wr_addr_o});
      else check("wr_req", {16'(cyc), vrf_wr_addr_o}, wrq_q.pop_front());
    end
    if (vrf_wr_en_o) begin
      if (wr_q.size() == 0) unexpected("wr_en", {16'(cyc), vrf_wr_elem_cnt_o});
      else check("wr_en", {16'(cyc), vrf_wr_addr_o, vrf_wr_elem_cnt_o, vrf_wdata_o, vrf_wr_ready_o},
                 wr_q.pop_front());
    end else if (vrf_wr_ready_o) begin
      unexpected("wr_ready_without_en", {16'(cyc), vrf_wr_elem_cnt_o});
    end
  end

  // ---------------- VRF read-completion model ----------------
  // Completion two cycles after the request, three when the C bank is also read.
  initial begin
    vrf_rd_op_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (vrf_rd_req_o) begin
        repeat (vrf_is_c_used_o ? 3 : 2) @(posedge clk_i);
        #1 vrf_rd_op_ready_i = 1'b1;
        @(posedge clk_i);
        #1 vrf_rd_op_ready_i = 1'b0;
      end
    end
  end

  // ---------------- driver / expectation tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_req(input int i, input bit v, input logic [AB-1:0] a, input logic [AB-1:0] b,
                         input logic [AB-1:0] c, input bit u);
    rq_valid_i[i]            = v;
    rq_a_addr_i[i*AB +: AB]  = a;
    rq_b_addr_i[i*AB +: AB]  = b;
    rq_c_addr_i[i*AB +: AB]  = c;
    rq_use_c_i[i]            = u;
  endtask

  task automatic push_gnt(input int c, input logic [1:0] g);
    gnt_q.push_back({16'(c), g});
  endtask

  task automatic push_rd(input int c, input logic [AB-1:0] a, input logic [AB-1:0] b,
                         input logic [AB-1:0] cc, input bit u);
    rdr_q.push_back({16'(c), a, b, cc, u});
  endtask

  task automatic push_op(input int c, input bit owner, input int idx, input logic [AB-1:0] a,
                         input logic [AB-1:0] b, input logic [AB-1:0] cc, input bit u);
    op_q.push_back({16'(c), owner, 2'(idx), (idx == 3), a, b, cc, u});
  endtask

  task automatic push_stream(input int c0, input bit owner, input logic [AB-1:0] a,
                             input logic [AB-1:0] b, input logic [AB-1:0] cc, input bit u);
    for (int k = 0; k < 4; k++) push_op(c0 + k, owner, k, a, b, cc, u);
  endtask

  task automatic push_wr(input int c, input logic [AB-1:0] addr, input int cnt,
                         input logic [DW-1:0] d, input bit rdy);
    wr_q.push_back({16'(c), addr, 2'(cnt), d, rdy});
  endtask

  task automatic check_idle(input string name);
    @(negedge clk_i);
    check({name, "_rd_outputs"}, {rq_grant_o, op_valid_o, op_idx_o, op_owner_o, op_last_o,
                                  vrf_rd_req_o, vrf_is_c_used_o, vrf_rd_elem_cnt_o}, 64'd0);
    check({name, "_addrs"}, {vrf_a_addr_o, vrf_b_addr_o, vrf_c_addr_o, vrf_wr_addr_o}, 64'd0);
    check({name, "_wr_outputs"}, {vrf_wr_req_o, vrf_wr_en_o, vrf_wr_ready_o, vrf_wr_elem_cnt_o,
                                  wdat_ready_o, wcmd_ready_o}, 64'b0000001);
    check({name, "_states"}, {dbg_rd_state_o, dbg_wr_state_o}, 64'd0);
    tick();
  endtask

  // ---------------- main sequence ----------------
  int t0;

  initial begin
    rst_i        = 1'b1;
    rq_valid_i   = '0;
    rq_a_addr_i  = '0;
    rq_b_addr_i  = '0;
    rq_c_addr_i  = '0;
    rq_use_c_i   = '0;
    op_ready_i   = 1'b1;
    wcmd_valid_i = 1'b0;
    wcmd_addr_i  = '0;
    wdat_valid_i = 1'b0;
    wdat_i       = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check_idle("reset");

    // Single request without C: grant G, rd_req G+1, operands G+4..G+7.
    t0 = cyc;
    set_req(0, 1'b1, 5'd3, 5'd5, 5'd0, 1'b0);
    push_gnt(t0, 2'b01);
    push_rd(t0 + 1, 5'd3, 5'd5, 5'd0, 1'b0);
    push_stream(t0 + 4, 1'b0, 5'd3, 5'd5, 5'd0, 1'b0);
    tick();
    set_req(0, 1'b0, 5'd3, 5'd5, 5'd0, 1'b0);
    goto_cycle(t0 + 8);

    // C operand on requester 1, one consumer stall on element 1.
    t0 = cyc;
    set_req(1, 1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
    push_gnt(t0, 2'b10);
    push_rd(t0 + 1, 5'd1, 5'd2, 5'd7, 1'b1);
    push_op(t0 + 5, 1'b1, 0, 5'd1, 5'd2, 5'd7, 1'b1);
    push_op(t0 + 7, 1'b1, 1, 5'd1, 5'd2, 5'd7, 1'b1);
    push_op(t0 + 8, 1'b1, 2, 5'd1, 5'd2, 5'd7, 1'b1);
    push_op(t0 + 9, 1'b1, 3, 5'd1, 5'd2, 5'd7, 1'b1);
    tick();
    set_req(1, 1'b0, 5'd1, 5'd2, 5'd7, 1'b1);
    goto_cycle(t0 + 6);
    op_ready_i = 1'b0;
    @(negedge clk_i);
    check("stall_hold", {op_valid_o, op_idx_o, op_last_o}, {1'b1, 2'd1, 1'b0});
    tick();
    op_ready_i = 1'b1;
    goto_cycle(t0 + 10);

    // Both requesters held valid: grants alternate 0,1,0,1 every 8 cycles.
    t0 = cyc;
    set_req(0, 1'b1, 5'd4, 5'd6, 5'd0, 1'b0);
    set_req(1, 1'b1, 5'd8, 5'd10, 5'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        push_gnt(t0 + 8*k, 2'b01);
        push_rd(t0 + 8*k + 1, 5'd4, 5'd6, 5'd0, 1'b0);
        push_stream(t0 + 8*k + 4, 1'b0, 5'd4, 5'd6, 5'd0, 1'b0);
      end else begin
        push_gnt(t0 + 8*k, 2'b10);
        push_rd(t0 + 8*k + 1, 5'd8, 5'd10, 5'd0, 1'b0);
        push_stream(t0 + 8*k + 4, 1'b1, 5'd8, 5'd10, 5'd0, 1'b0);
      end
    end
    goto_cycle(t0 + 25);
    set_req(0, 1'b0, 5'd4, 5'd6, 5'd0, 1'b0);
    set_req(1, 1'b0, 5'd8, 5'd10, 5'd0, 1'b0);
    goto_cycle(t0 + 32);

    // Write stream to reg 12 with one-cycle bubbles between elements.
    t0 = cyc;
    wcmd_valid_i = 1'b1;
    wcmd_addr_i  = 5'd12;
    push_wr_req: begin
      wrq_q.push_back({16'(t0 + 1), 5'd12});
    end
    tick();
    wcmd_valid_i = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      wdat_valid_i = 1'b1;
      wdat_i       = 32'hA0 + k;
      push_wr(t0 + 2 + 2*k, 5'd12, k, 32'hA0 + k, (k == 3));
      tick();
      wdat_valid_i = 1'b0;
      if (k < 3) begin
        @(negedge clk_i);
        check("wdata_bubble", {wcmd_ready_o, wdat_ready_o, vrf_wr_en_o, vrf_wr_elem_cnt_o},
              {1'b0, 1'b1, 1'b0, 2'(k + 1)});
        tick();
      end
    end
    @(negedge clk_i);
    check("write_done_idle", {wcmd_ready_o, wdat_ready_o, dbg_wr_state_o}, {1'b1, 1'b0, W_IDLE});
    tick();

    // Hazard: reg 5 being written blocks requester 0 (b=5) until wr_ready;
    // requester 1 carries c=5 without use_c so it stays eligible.
    t0 = cyc;
    wcmd_valid_i = 1'b1;
    wcmd_addr_i  = 5'd5;
    wrq_q.push_back({16'(t0 + 1), 5'd5});
    tick();
    wcmd_valid_i = 1'b0;
    tick();
    set_req(0, 1'b1, 5'd1, 5'd5, 5'd0, 1'b0);
    set_req(1, 1'b1, 5'd9, 5'd9, 5'd5, 1'b0);
    push_gnt(t0 + 2, 2'b10);
    push_rd(t0 + 3, 5'd9, 5'd9, 5'd5, 1'b0);
    push_stream(t0 + 6, 1'b1, 5'd9, 5'd9, 5'd5, 1'b0);
    tick();
    set_req(1, 1'b0, 5'd9, 5'd9, 5'd5, 1'b0);
    goto_cycle(t0 + 10);
    for (int k = 0; k < 4; k++) begin
      wdat_valid_i = 1'b1;
      wdat_i       = 32'hB0 + k;
      push_wr(t0 + 10 + k, 5'd5, k, 32'hB0 + k, (k == 3));
      tick();
    end
    wdat_valid_i = 1'b0;
    push_gnt(t0 + 14, 2'b01);
    push_rd(t0 + 15, 5'd1, 5'd5, 5'd0, 1'b0);
    push_stream(t0 + 18, 1'b0, 5'd1, 5'd5, 5'd0, 1'b0);
    tick();
    set_req(0, 1'b0, 5'd1, 5'd5, 5'd0, 1'b0);
    goto_cycle(t0 + 22);

    // Reset while streaming element 2.
    t0 = cyc;
    set_req(0, 1'b1, 5'd2, 5'd3, 5'd0, 1'b0);
    push_gnt(t0, 2'b01);
    push_rd(t0 + 1, 5'd2, 5'd3, 5'd0, 1'b0);
    push_op(t0 + 4, 1'b0, 0, 5'd2, 5'd3, 5'd0, 1'b0);
    push_op(t0 + 5, 1'b0, 1, 5'd2, 5'd3, 5'd0, 1'b0);
    push_op(t0 + 6, 1'b0, 2, 5'd2, 5'd3, 5'd0, 1'b0);
    tick();
    set_req(0, 1'b0, 5'd2, 5'd3, 5'd0, 1'b0);
    goto_cycle(t0 + 6);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_idle("mid_stream_reset");

    // After reset requester 0 has priority again; streams restart at element 0.
    t0 = cyc;
    set_req(0, 1'b1, 5'd2, 5'd3, 5'd0, 1'b0);
    set_req(1, 1'b1, 5'd11, 5'd12, 5'd0, 1'b0);
    push_gnt(t0, 2'b01);
    push_rd(t0 + 1, 5'd2, 5'd3, 5'd0, 1'b0);
    push_stream(t0 + 4, 1'b0, 5'd2, 5'd3, 5'd0, 1'b0);
    push_gnt(t0 + 8, 2'b10);
    push_rd(t0 + 9, 5'd11, 5'd12, 5'd0, 1'b0);
    push_stream(t0 + 12, 1'b1, 5'd11, 5'd12, 5'd0, 1'b0);
    tick();
    set_req(0, 1'b0, 5'd2, 5'd3, 5'd0, 1'b0);
    goto_cycle(t0 + 9);
    set_req(1, 1'b0, 5'd11, 5'd12, 5'd0, 1'b0);
    goto_cycle(t0 + 16);
    repeat (4) tick();

    check("grants_outstanding", gnt_q.size(), 0);
    check("rd_reqs_outstanding", rdr_q.size(), 0);
    check("operands_outstanding", op_q.size(), 0);
    check("wr_reqs_outstanding", wrq_q.size(), 0);
    check("wr_elems_outstanding", wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_checks++;
    n_fail++;
    $display("FAIL timeout: sequence did not complete (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vrf_access_ctrl.md
Name: vrf_access_ctrl

Overview:
- Sequences and shares the banked vector register file between NREQ read requesters and one write-back stream.
- Read side: round-robin arbitration; drives the VRF read handshake (rd_req / is_c_used / rd_op_ready) for the winner; streams the fetched operands element by element through the VRF element-select index.
- Write side: drives the VRF write handshake (wr_req / wr_en / wr_ready / wr_elem_cnt) for one destination register, element by element.
- Sits between the issue/LSU stage and the VRF.

Parameters:
- DATA_WIDTH, 32, element width
- REG_NUM, 32, architectural vector registers
- LANES, 4, elements (banks) per register
- NREQ, 2, read requesters
- ADDR_B, $clog2(REG_NUM), register address width (localparam)
- ELEM_B, $clog2(LANES), element index width (localparam)
- REQ_B, $clog2(NREQ), requester index width (localparam)

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- rq_valid_i  in  NREQ  read request per requester; held until granted
- rq_a_addr_i / rq_b_addr_i / rq_c_addr_i  in  NREQ*ADDR_B each  source register addresses, packed, requester i at [i*ADDR_B +: ADDR_B]
- rq_use_c_i  in  NREQ  third operand needed
- rq_grant_o  out  NREQ  one-hot, one-cycle pulse on acceptance
- op_valid_o  out  1  element operands valid (data comes from the VRF a/b/c rdata)
- op_idx_o  out  ELEM_B  element index being presented
- op_owner_o  out  REQ_B  requester owning the current stream
- op_last_o  out  1  op_idx_o == LANES-1
- op_ready_i  in  1  consumer accepts the current element
- wcmd_valid_i  in  1  write command
- wcmd_addr_i  in  ADDR_B  destination register
- wcmd_ready_o  out  1  write command accepted when valid && ready
- wdat_valid_i  in  1  write element valid
- wdat_i  in  DATA_WIDTH  write element data
- wdat_ready_o  out  1  write element accepted
- vrf_a_addr_o / vrf_b_addr_o / vrf_c_addr_o  out  ADDR_B each  latched winner addresses
- vrf_rd_req_o  out  1  VRF read request
- vrf_is_c_used_o  out  1  latched use_c
- vrf_rd_op_ready_i  in  1  VRF read-sequence completion
- vrf_rd_elem_cnt_o  out  ELEM_B  equals op_idx_o
- vrf_wr_addr_o  out  ADDR_B  latched write destination
- vrf_wr_req_o / vrf_wr_en_o / vrf_wr_ready_o  out  1 each  VRF write handshake
- vrf_wr_elem_cnt_o  out  ELEM_B  write element index
- vrf_wdata_o  out  DATA_WIDTH  equals wdat_i (combinational)

Behaviour:
- Reset: all state synchronous on rst_i=1.
  - Read FSM to R_IDLE; write FSM to W_IDLE.
  - All outputs 0, counters 0, latched addresses 0.
  - Round-robin pointer to 0, so requester 0 has highest priority first.
  - A reset mid-operation abandons the stream; nothing partial completes.
- Read FSM states R_IDLE, R_ISSUE, R_FETCH, R_STREAM.
  - R_IDLE: pick the first eligible requester starting from ptr+1 (mod NREQ).
    - Eligible = rq_valid_i=1 and no write hazard.
    - On a pick: pulse rq_grant_o, latch addrs/use_c/owner, ptr<=winner, go to R_ISSUE.
  - R_ISSUE: vrf_rd_req_o=1 for exactly one cycle, then go to R_FETCH.
  - R_FETCH: wait for vrf_rd_op_ready_i=1, then go to R_STREAM; operands are valid from the next cycle.
  - R_STREAM: op_valid_o=1 and op_idx_o=cnt.
    - On op_ready_i=1: cnt++.
    - If cnt==LANES-1 at acceptance: cnt<=0, go to R_IDLE.
  - Read latency: grant cycle G; first op_valid_o at G+4 (no C) or G+5 (C).
- Write hazard: requester i is ineligible while the write FSM is W_REQ or W_DATA and vrf_wr_addr_o equals rq_a_addr, rq_b_addr, or (rq_use_c=1 and rq_c_addr).
- Write FSM states W_IDLE, W_REQ, W_DATA.
  - W_IDLE: wcmd_ready_o=1. On a command: latch addr, go to W_REQ.
  - W_REQ: vrf_wr_req_o=1 for one cycle, then go to W_DATA.
  - W_DATA: wdat_ready_o=1; wcnt drives vrf_wr_elem_cnt_o.
    - On wdat_valid_i: vrf_wr_en_o=1 that cycle, wcnt++.
    - On the last element (wcnt==LANES-1): vrf_wr_ready_o=1 the same cycle, wcnt<=0, go to W_IDLE.
  - A stalled wdat_valid_i holds W_DATA indefinitely.
- Read and write FSMs are independent; simultaneous grant and write command in one cycle are both legal.
- vrf_*_addr_o stay stable from R_ISSUE through R_STREAM.
- Counter wrap is explicit, so LANES need not be a power of two.

Decomposition:
- Package vrf_ctrl_pkg holds:
  - rd_state_e, wr_state_e enums
  - ADDR_B/ELEM_B derivation functions
- Sub-module rr_arbiter (NREQ, req/eligible in, one-hot grant out, pointer update enable) instantiated once.

Test Plan:
- Single request: req0 a=3, b=5, use_c=0 → grant at cycle G, vrf_rd_req_o at G+1, op_valid_o from G+4, idx 0,1,2,3 with op_ready_i=1 continuous, op_last_o at idx 3.
- C operand: req1 use_c=1, c=7 → vrf_is_c_used_o=1, first op_valid_o at G+5.
- Round robin: both requesters valid continuously → grants alternate 0,1,0,1; op_owner_o matches each stream.
- Hazard: write to reg 5 in W_DATA while req0 reads b=5 and req1 reads reg 9 → req1 granted first; req0 is granted only after vrf_wr_ready_o.
- Write stream: wcmd addr=12, elements 0xA0..0xA3 with one-cycle bubbles → vrf_wr_req_o once, vrf_wr_en_o four times with elem_cnt 0..3, vrf_wr_ready_o with element 3.
- Reset mid-stream: rst_i=1 in R_STREAM at idx 2 → next cycle all outputs 0 and FSMs idle; a new request restarts at idx 0.
